bram_stream_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that sits directly upstream of blockram_single_port and is its only master.
- Turns a valid/ready write stream and a valid/ready read stream into single-port RAM accesses, with at most one access per cycle.
- Consumes data_out through a one-word output register, which also serves as the FIFO head.
- Intended as the standard buffering wrapper around the single-port block RAM.

---
 rtl/bram_stream_fifo_ctrl.sv | 128 ++++++++++++
 tb/tb_bram_stream_fifo_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_fifo_ctrl.sv
// bram_stream_fifo_ctrl
// Stream FIFO controller that is the only master of a single-port block RAM.
// Converts a valid/ready write stream and a valid/ready read stream into at
// most one RAM access per cycle. A one-word output register holds the FIFO
// head; RAM reads have priority over writes so the head is refilled promptly.
// Optional feature: define BRAM_STREAM_FIFO_BYPASS_EN to let a push into an
// otherwise empty FIFO load the output register directly, skipping the RAM.

module bram_stream_fifo_ctrl #(
    parameter int RAM_WIDTH = 16,
    parameter int RAM_DEPTH = 1024,
    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
    localparam int CW = $clog2(RAM_DEPTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RAM_WIDTH-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [CW-1:0]        count,
    output logic                 full,
    output logic                 empty,
    output logic                 write_enable,
    output logic                 read_enable,
    output logic [AW-1:0]        address,
    output logic [RAM_WIDTH-1:0] data_in,
    input  logic [RAM_WIDTH-1:0] data_out
);

    localparam logic [CW-1:0] DEPTH_C  = CW'(RAM_DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(RAM_DEPTH - 1);

    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        addr_q;
    logic [RAM_WIDTH-1:0] data_q;
    logic [CW-1:0]        ram_cnt;
    logic [CW-1:0]        ram_cnt_next;
    logic                 rd_pending;
    logic                 pop;
    logic                 push;
    logic                 read_issue;
    logic                 ram_write;
    logic                 bypass_load;

    // Handshake decode, read-over-write arbitration and RAM port drive.
    always_comb begin
        pop        = m_valid && m_ready;
        read_issue = !rd_pending && (ram_cnt != '0) && (!m_valid || pop);
        s_ready    = !rst && (ram_cnt < DEPTH_C) && !read_issue;
        push       = s_valid && s_ready;
`ifdef BRAM_STREAM_FIFO_BYPASS_EN
        bypass_load = push && (ram_cnt == '0) && !rd_pending && (!m_valid || pop);
`else
        bypass_load = 1'b0;
`endif
        ram_write    = push && !bypass_load;
        write_enable = ram_write;
        read_enable  = read_issue;
        address      = addr_q;
        data_in      = data_q;
        if (read_issue) begin
            address = rd_ptr;
        end else if (ram_write) begin
            address = wr_ptr;
            data_in = s_data;
        end
        ram_cnt_next = ram_cnt;
        if (ram_write && !read_issue) begin
            ram_cnt_next = ram_cnt + CW'(1);
        end else if (read_issue && !ram_write) begin
            ram_cnt_next = ram_cnt - CW'(1);
        end
        count = ram_cnt + CW'(rd_pending) + CW'(m_valid);
        empty = (count == '0);
    end

    // RAM-side bookkeeping: pointers with wrap, occupancy, read in flight,
    // and the last address/data so an idle bus holds its previous value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            full       <= 1'b0;
            rd_pending <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            if (ram_write) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
                data_q <= s_data;
            end
            if (read_issue) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
            end
            if (ram_write || read_issue) begin
                addr_q <= address;
            end
            ram_cnt    <= ram_cnt_next;
            full       <= (ram_cnt_next == DEPTH_C);
            rd_pending <= read_issue;
        end
    end

    // Output register: captures returning RAM data (or a bypassed push) and
    // drops valid when the head is popped with nothing arriving behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data  <= '0;
            m_valid <= 1'b0;
        end else begin
            if (rd_pending) begin
                m_data  <= data_out;
                m_valid <= 1'b1;
            end else if (bypass_load) begin
                m_data  <= s_data;
                m_valid <= 1'b1;
            end else if (pop) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bram_stream_fifo_ctrl.sv
// Testbench for bram_stream_fifo_ctrl with a small behavioural single-port RAM.

module tb_bram_stream_fifo_ctrl;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int AW = $clog2(D);
    localparam int CW = $clog2(D + 2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          write_enable;
    logic          read_enable;
    logic [AW-1:0] address;
    logic [W-1:0]  data_in;
    logic [W-1:0]  data_out;

    logic [W-1:0]  mem [0:D-1];
    logic          last_we = 1'b0;
    logic [W-1:0]  last_din = '0;
    bit            excl_en = 1'b0;
    int            checks = 0;
    int            failures = 0;

    bram_stream_fifo_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .count(count), .full(full), .empty(empty),
        .write_enable(write_enable), .read_enable(read_enable),
        .address(address), .data_in(data_in), .data_out(data_out)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: registered read, one cycle latency.
    always @(posedge clk) begin
        if (write_enable) mem[address] <= data_in;
        if (read_enable) data_out <= mem[address];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // The RAM port must never see a read and a write in the same cycle.
    always @(negedge clk) begin
        if (excl_en) checkOutput("port_excl", 32'(write_enable & read_enable), 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushWord(input logic [W-1:0] d, input string tag);
        bit ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (s_ready) begin
                ok       = 1'b1;
                last_we  = write_enable;
                last_din = data_in;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        s_valid = 1'b0;
        if (!ok) checkOutput({tag, "_push_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic popWord(input logic [W-1:0] exp, input string tag);
        bit ok = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (m_valid) begin
                ok = 1'b1;
                checkOutput(tag, 32'(m_data), 32'(exp));
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        m_ready = 1'b0;
        if (!ok) checkOutput({tag, "_pop_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input int base, input int n, input int push_gap,
                                 input int pop_stall, input string tag);
        fork
            begin
                for (int k = 0; k < n; k++) begin
                    pushWord(W'(base + k), {tag, "_in"});
                    if (push_gap != 0) repeat (k % push_gap) tick();
                end
            end
            begin
                int got = 0;
                for (int c = 0; c < 2000 && got < n; c++) begin
                    m_ready = (pop_stall == 0) ? 1'b1 : ((c % pop_stall) != 0);
                    #1;
                    if (m_valid && m_ready) begin
                        checkOutput({tag, "_order"}, 32'(m_data), 32'(base + got));
                        got++;
                    end
                    @(posedge clk);
                    #1;
                end
                m_ready = 1'b0;
                checkOutput({tag, "_count"}, 32'(got), 32'(n));
            end
        join
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int lat;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_m_data", 32'(m_data), 32'd0);
        checkOutput("rst_we", 32'(write_enable), 32'd0);
        checkOutput("rst_re", 32'(read_enable), 32'd0);
        checkOutput("rst_address", 32'(address), 32'd0);
        checkOutput("rst_data_in", 32'(data_in), 32'd0);
        rst = 1'b0;
        tick();
        excl_en = 1'b1;

        $display("[TB] empty-to-valid latency");
        pushWord(16'h5A5A, "lat");
        lat = 1;
        while (!m_valid && lat < 8) begin
            tick();
            lat++;
        end
`ifdef BRAM_STREAM_FIFO_BYPASS_EN
        checkOutput("lat_cycles", 32'(lat), 32'd1);
        checkOutput("lat_we", 32'(last_we), 32'd0);
`else
        checkOutput("lat_cycles", 32'(lat), 32'd3);
        checkOutput("lat_we", 32'(last_we), 32'd1);
        checkOutput("lat_data_in", 32'(last_din), 32'h5A5A);
`endif
        popWord(16'h5A5A, "lat_data");
        checkOutput("drain_m_valid", 32'(m_valid), 32'd0);
        checkOutput("drain_m_data_hold", 32'(m_data), 32'h5A5A);
        checkOutput("drain_empty", 32'(empty), 32'd1);

        $display("[TB] ordered transfer");
        pushWord(16'hABCD, "ord");
        pushWord(16'hCDEF, "ord");
        repeat (4) tick();
        checkOutput("ord_count", 32'(count), 32'd2);
        popWord(16'hABCD, "ord_first");
        popWord(16'hCDEF, "ord_second");
        repeat (3) tick();
        checkOutput("ord_empty", 32'(empty), 32'd1);

        $display("[TB] full");
        for (int k = 0; k < 5; k++) pushWord(W'(16'h1000 + k), "full");
        repeat (3) tick();
        checkOutput("full_flag", 32'(full), 32'd1);
        checkOutput("full_count", 32'(count), 32'd5);
        s_valid = 1'b1;
        s_data  = 16'h1005;
        repeat (3) begin
            #1;
            checkOutput("full_s_ready", 32'(s_ready), 32'd0);
            tick();
        end
        checkOutput("full_count_held", 32'(count), 32'd5);
        popWord(16'h1000, "full_pop0");
        checkOutput("full_cleared", 32'(full), 32'd0);
        pushWord(16'h1005, "full_sixth");
        for (int k = 1; k < 6; k++) popWord(W'(16'h1000 + k), "full_pop");
        repeat (3) tick();
        checkOutput("full_empty", 32'(empty), 32'd1);

        $display("[TB] reset mid-stream");
        for (int k = 0; k < 5; k++) pushWord(W'(16'h2000 + k), "mrst");
        repeat (2) tick();
        checkOutput("mrst_count_before", 32'(count), 32'd5);
        s_valid = 1'b1;
        s_data  = 16'h2005;
        m_ready = 1'b1;
        rst = 1'b1;
        #1;
        checkOutput("mrst_count", 32'(count), 32'd0);
        checkOutput("mrst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("mrst_we", 32'(write_enable), 32'd0);
        checkOutput("mrst_re", 32'(read_enable), 32'd0);
        checkOutput("mrst_empty", 32'(empty), 32'd1);
        tick();
        rst = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        tick();
        pushWord(16'h1234, "mrst");
        popWord(16'h1234, "mrst_first");
        repeat (3) tick();
        checkOutput("mrst_empty_after", 32'(empty), 32'd1);

        $display("[TB] continuous stream");
        applyStimulus(0, 100, 0, 0, "stream");
        repeat (3) tick();
        checkOutput("stream_empty", 32'(empty), 32'd1);

        $display("[TB] wrap-around with stalls");
        applyStimulus(0, 10, 3, 3, "wrap");
        repeat (3) tick();
        checkOutput("wrap_empty", 32'(empty), 32'd1);

        excl_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
